// File: rtl/broadcast_scheduler.sv
// rtl/broadcast_scheduler.sv - field-synchronous round-robin broadcast source scheduler
// Build option: SCHED_MUTE_EN adds a MUTE state that drops the carrier for MUTE_FIELDS fields on each source switch.
module broadcast_scheduler #(
   parameter int VSYNC_MIN_LOW = 128,
   parameter int HOLDOFF       = 16384,
   parameter int DWELL_FIELDS  = 250,
   parameter int MUTE_FIELDS   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       csync,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic       carrier_en,
   output logic       field_start,
   output logic [1:0] slot
);

   // One counter serves as dwell counter in ON_AIR and mute counter in MUTE.
   localparam int CNT_MAX = (DWELL_FIELDS > MUTE_FIELDS) ? DWELL_FIELDS : MUTE_FIELDS;
   localparam int LW      = $clog2(VSYNC_MIN_LOW + 2);
   localparam int HW      = $clog2(HOLDOFF + 2);
   localparam int CW      = $clog2(CNT_MAX + 2);

   localparam logic [LW-1:0] LOW_MAX  = LW'(VSYNC_MIN_LOW);
   localparam logic [LW-1:0] LOW_HIT  = LW'(VSYNC_MIN_LOW - 1);
   localparam logic [HW-1:0] HOLD_LD  = HW'(HOLDOFF);
   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_FIELDS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ON_AIR = 2'd1;
`ifdef SCHED_MUTE_EN
   localparam logic [1:0] S_MUTE   = 2'd2;
   localparam logic [CW-1:0] MUTE_LD = CW'(MUTE_FIELDS);
`endif

   logic [LW-1:0] low_cnt_q;
   logic [HW-1:0] hold_q;
   logic          fs_q;
   logic          fs_d;
   logic [1:0]    state_q, state_d;
   logic [1:0]    slot_q, slot_d;
   logic          carrier_q, carrier_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_dec;
   logic [1:0]    low_slot;
   logic          rr_found;
   logic [1:0]    rr_slot;
   logic [1:0]    rr_idx;

   // A broad pulse is recognised the cycle its low run first hits the threshold, and only while armed.
   assign fs_d    = (hold_q == '0) && !csync && (low_cnt_q == LOW_HIT);
   assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CW'(1);

   // Low-run counter, holdoff timer and registered field_start pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         low_cnt_q <= '0;
         hold_q    <= '0;
         fs_q      <= 1'b0;
      end else begin
         if (csync)
            low_cnt_q <= '0;
         else if (low_cnt_q != LOW_MAX)
            low_cnt_q <= low_cnt_q + LW'(1);
         if (fs_d)
            hold_q <= HOLD_LD;
         else if (hold_q != '0)
            hold_q <= hold_q - HW'(1);
         fs_q <= fs_d;
      end
   end

   // Lowest requester, and next requester in round-robin order after the current slot (itself last)
   always_comb begin
      low_slot = 2'd0;
      for (int i = 3; i >= 0; i--)
         if (req[i]) low_slot = 2'(i);
      rr_found = 1'b0;
      rr_slot  = slot_q;
      rr_idx   = slot_q;
      for (int i = 1; i <= 4; i++) begin
         rr_idx = slot_q + 2'(i);
         if (!rr_found && req[rr_idx]) begin
            rr_found = 1'b1;
            rr_slot  = rr_idx;
         end
      end
   end

   // Scheduler next state; nothing moves except on a field_start cycle
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      carrier_d = carrier_q;
      cnt_d     = cnt_q;
      if (fs_q) begin
         case (state_q)
            S_IDLE: begin
               if (req != 4'b0000) begin
                  state_d   = S_ON_AIR;
                  slot_d    = low_slot;
                  carrier_d = 1'b1;
                  cnt_d     = DWELL_LD;
               end
            end
            S_ON_AIR: begin
               cnt_d = cnt_dec;
               // Dwell expiry and a dropped request collapse into one switch decision.
               if (cnt_dec == '0 || !req[slot_q]) begin
                  if (!rr_found) begin
                     state_d   = S_IDLE;
                     slot_d    = 2'd0;
                     carrier_d = 1'b0;
                     cnt_d     = '0;
                  end else if (rr_slot == slot_q) begin
                     cnt_d = DWELL_LD;
                  end else begin
`ifdef SCHED_MUTE_EN
                     state_d   = S_MUTE;
                     carrier_d = 1'b0;
                     cnt_d     = MUTE_LD;
`else
                     cnt_d     = DWELL_LD;
`endif
                     slot_d    = rr_slot;
                  end
               end
            end
`ifdef SCHED_MUTE_EN
            S_MUTE: begin
               cnt_d = cnt_dec;
               if (cnt_dec == '0) begin
                  if (req[slot_q]) begin
                     state_d   = S_ON_AIR;
                     carrier_d = 1'b1;
                     cnt_d     = DWELL_LD;
                  end else if (rr_found) begin
                     state_d   = S_ON_AIR;
                     slot_d    = rr_slot;
                     carrier_d = 1'b1;
                     cnt_d     = DWELL_LD;
                  end else begin
                     state_d   = S_IDLE;
                     slot_d    = 2'd0;
                     carrier_d = 1'b0;
                     cnt_d     = '0;
                  end
               end
            end
`endif
            default: begin
               state_d   = S_IDLE;
               slot_d    = 2'd0;
               carrier_d = 1'b0;
               cnt_d     = '0;
            end
         endcase
      end
   end

   // Scheduler state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         slot_q    <= 2'd0;
         carrier_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         carrier_q <= carrier_d;
         cnt_q     <= cnt_d;
      end
   end

   assign grant       = (state_q == S_IDLE) ? 4'b0000 : (4'b0001 << slot_q);
   assign slot        = slot_q;
   assign carrier_en  = carrier_q;
   assign field_start = fs_q;

endmodule

// File: tb/tb_broadcast_scheduler.sv
// tb/tb_broadcast_scheduler.sv - randomized self-checking bench for broadcast_scheduler
module tb_broadcast_scheduler;

   localparam int VMIN  = 8;
   localparam int HOLD  = 80;
   localparam int DWELL = 4;
   localparam int MUTEF = 2;
`ifdef SCHED_MUTE_EN
   localparam bit MUTE_EN = 1'b1;
`else
   localparam bit MUTE_EN = 1'b0;
`endif

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       csync = 1'b1;
   logic [3:0] req   = 4'b0000;
   logic [3:0] grant;
   logic       carrier_en;
   logic       field_start;
   logic [1:0] slot;
   logic [7:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   broadcast_scheduler #(
      .VSYNC_MIN_LOW(VMIN),
      .HOLDOFF(HOLD),
      .DWELL_FIELDS(DWELL),
      .MUTE_FIELDS(MUTEF)
   ) dut (
      .clk(clk),
      .rst(rst),
      .csync(csync),
      .req(req),
      .grant(grant),
      .carrier_en(carrier_en),
      .field_start(field_start),
      .slot(slot)
   );

   always #5 clk = ~clk;

   assign obs = {field_start, carrier_en, slot, grant};

   // ---------------- reference model ----------------
   longint cyc       = 0;
   longint last_fire = -1000000;
   int     run_len   = 0;
   bit     m_fs      = 1'b0;
   bit     m_on      = 1'b0;
   bit     m_mute    = 1'b0;
   bit     m_carrier = 1'b0;
   int     m_slot    = 0;
   int     m_left    = 0;
   bit     field_pat[$];

   task automatic model_reset();
      last_fire = -1000000;
      run_len   = 0;
      m_fs      = 1'b0;
      m_on      = 1'b0;
      m_mute    = 1'b0;
      m_carrier = 1'b0;
      m_slot    = 0;
      m_left    = 0;
   endtask

   task automatic model_idle();
      m_on      = 1'b0;
      m_mute    = 1'b0;
      m_carrier = 1'b0;
      m_slot    = 0;
      m_left    = 0;
   endtask

   function automatic int next_after(input int from, input logic [3:0] r);
      for (int k = 1; k <= 4; k++)
         if (r[(from + k) % 4]) return (from + k) % 4;
      return -1;
   endfunction

   task automatic model_sched(input logic [3:0] r);
      int t;
      if (!m_on) begin
         if (r != 4'b0000) begin
            m_on = 1'b1; m_slot = next_after(3, r); m_carrier = 1'b1; m_left = DWELL;
         end
      end else if (m_mute) begin
         m_left = (m_left > 0) ? m_left - 1 : 0;
         if (m_left == 0) begin
            m_mute = 1'b0;
            t = r[m_slot] ? m_slot : next_after(m_slot, r);
            if (t < 0) model_idle();
            else begin m_slot = t; m_carrier = 1'b1; m_left = DWELL; end
         end
      end else begin
         m_left = (m_left > 0) ? m_left - 1 : 0;
         if (m_left == 0 || !r[m_slot]) begin
            t = next_after(m_slot, r);
            if (t < 0) model_idle();
            else if (t == m_slot) m_left = DWELL;
            else if (MUTE_EN) begin m_mute = 1'b1; m_carrier = 1'b0; m_slot = t; m_left = MUTEF; end
            else begin m_slot = t; m_left = DWELL; end
         end
      end
   endtask

   task automatic model_edge(input bit cs, input logic [3:0] r);
      if (m_fs) model_sched(r);
      run_len = cs ? 0 : run_len + 1;
      m_fs = (run_len == VMIN) && (cyc - last_fire > HOLD);
      if (m_fs) last_fire = cyc;
   endtask

   function automatic logic [7:0] exp_vec();
      logic [3:0] g;
      g = m_on ? 4'(1 << m_slot) : 4'b0000;
      return {m_fs, m_carrier, (m_on ? 2'(m_slot) : 2'b00), g};
   endfunction

   // One clock: inputs change at the falling edge, outputs are compared 1 unit after the rising edge.
   task automatic cycle(input bit rst_v, input bit cs, input logic [3:0] r);
      @(negedge clk);
      rst = rst_v; csync = cs; req = r;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_v) model_reset();
      else model_edge(cs, r);
   endtask

   // PAL-like field scaled down: 5 broad pulses, 5 equalizing pulses, 6 lines of hsync.
   task automatic make_field();
      int lo;
      field_pat.delete();
      repeat (5) begin
         lo = $urandom_range(VMIN + 1, VMIN + 6);
         repeat (lo) field_pat.push_back(1'b0);
         repeat (3) field_pat.push_back(1'b1);
      end
      repeat (5) begin
         repeat (4) field_pat.push_back(1'b0);
         repeat (11) field_pat.push_back(1'b1);
      end
      repeat (6) begin
         lo = $urandom_range(2, VMIN - 1);
         repeat (lo) field_pat.push_back(1'b0);
         repeat (12) field_pat.push_back(1'b1);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'($urandom_range(0, 1)), 4'($urandom));
         n_checks++;
         if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state cycle %0d got %b want %b", cyc, obs, 8'h00);
         end
      end
   endtask

   task automatic test_single_source();
      for (int f = 0; f < 12; f++) begin
         make_field();
         foreach (field_pat[i]) begin
            cycle(1'b0, field_pat[i], 4'b0001);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_fail++;
               $display("FAIL single_source cycle %0d got %b want %b", cyc, obs, exp_vec());
            end
         end
      end
      n_checks++;
      if ({carrier_en, grant} !== 5'b1_0001) begin
         n_fail++;
         $display("FAIL single_source_hold got %b want %b", {carrier_en, grant}, 5'b1_0001);
      end
   endtask

   task automatic test_round_robin(input logic [3:0] r, input int fields);
      for (int f = 0; f < fields; f++) begin
         make_field();
         foreach (field_pat[i]) begin
            cycle(1'b0, field_pat[i], r);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_fail++;
               $display("FAIL round_robin req %b cycle %0d got %b want %b", r, cyc, obs, exp_vec());
            end
         end
      end
   endtask

   task automatic test_req_drop();
      for (int f = 0; f < 6; f++) begin
         make_field();
         foreach (field_pat[i]) begin
            cycle(1'b0, field_pat[i], 4'b0100);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_fail++;
               $display("FAIL req_drop_setup cycle %0d got %b want %b", cyc, obs, exp_vec());
            end
         end
      end
      n_checks++;
      if (grant !== 4'b0100) begin
         n_fail++;
         $display("FAIL req_drop_slot2 got %b want %b", grant, 4'b0100);
      end
      make_field();
      foreach (field_pat[i]) begin
         cycle(1'b0, field_pat[i], 4'b1001);
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL req_drop cycle %0d got %b want %b", cyc, obs, exp_vec());
         end
      end
      n_checks++;
      if (grant !== 4'b1000) begin
         n_fail++;
         $display("FAIL req_drop_slot3 got %b want %b", grant, 4'b1000);
      end
   endtask

   task automatic test_stuck_low();
      int pulses = 0;
      for (int i = 0; i < 400; i++) begin
         cycle(1'b0, 1'b0, 4'b1111);
         if (field_start === 1'b1) pulses++;
         n_checks++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL stuck_low cycle %0d got %b want %b", cyc, obs, exp_vec());
         end
      end
      n_checks++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL stuck_low_pulses got %0d want %0d", pulses, 1);
      end
      test_round_robin(4'b1111, 3);
   endtask

   task automatic test_random();
      logic [3:0] r;
      int         cut;
      r = 4'($urandom);
      for (int f = 0; f < 25; f++) begin
         make_field();
         cut = $urandom_range(0, field_pat.size() - 1);
         foreach (field_pat[i]) begin
            if (i == cut) r = 4'($urandom);
            cycle(1'b0, field_pat[i], r);
            n_checks++;
            if (obs !== exp_vec()) begin
               n_fail++;
               $display("FAIL random cycle %0d req %b got %b want %b", cyc, r, obs, exp_vec());
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int cut;
      test_round_robin(4'b0101, DWELL + 1);
      make_field();
      cut = $urandom_range(20, field_pat.size() - 1);
      for (int i = 0; i < cut; i++) cycle(1'b0, field_pat[i], 4'b0101);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if ({carrier_en, grant, slot} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_async got %b want %b", {carrier_en, grant, slot}, 7'b0);
      end
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 4'b0101);
         n_checks++;
         if (obs !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d got %b want %b", cyc, obs, 8'h00);
         end
      end
      for (int i = 0; i < 20; i++) begin
         cycle(1'b0, 1'b1, 4'b0101);
         n_checks++;
         if (grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_no_grant cycle %0d got %b want %b", cyc, grant, 4'b0000);
         end
      end
      test_round_robin(4'b0101, 3);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_source();
      test_round_robin(4'b0101, 16);
      test_round_robin(4'b0011, 12);
      test_req_drop();
      test_stuck_low();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
